w_load_writeback_unit: RTL and testbench
========================================

# w_load_writeback_unit

Writeback-stage load unit on the M→W boundary of the five-stage pipeline. It latches the M-stage memory read word, address low bits and writeback control into the W pipeline register. It extracts and extends byte, halfword or word load data and drives the final register-file writeback value, which is also the W→M store-data forwarding source. It also produces the select that steers M-stage store data to the forwarded W value.

## Interface
Parameters: none.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears the W register
- W_En  in  1  1 = load new M values this edge; 0 = hold
- W_Clr  in  1  synchronous bubble insert (priority below reset, above W_En)
- M_ReadData  in  32  word read from data memory (word-aligned)
- M_Addr  in  32  memory address of the M-stage instruction
- M_LoadType  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101–111 treated as LW
- M_WBSel  in  1  1 = writeback from memory, 0 = from M_ALUData
- M_ALUData  in  32  non-memory writeback value (ALU result / PC+8)
- M_RegWrite  in  1  M-stage instruction writes a register
- M_WriteReg  in  5  destination register number
- M_rt  in  5  rt of the M-stage instruction (store-data source)
- W_ForwardStoreData  out  32  final writeback value; also the forwarding source
- W_WriteReg  out  5  registered destination
- W_RegWrite  out  1  effective register write enable
- M_ForwardStoreDataMux_Sel  out  1  1 = M store data uses W_ForwardStoreData

## Operation
- W register fields: ReadData[31:0], Addr[1:0], LoadType[2:0], WBSel, ALUData[31:0], RegWrite, WriteReg[4:0].
- Update priority per edge: reset → all fields 0; else W_Clr → all fields 0 (bubble); else W_En → capture M inputs; else hold.
- Extraction happens combinationally from the registered fields. Byte lane = Addr[1:0] (lane 0 = bits 7:0). Half lane = Addr[1] (0 = bits 15:0).
- LB sign-extends the byte; LBU zero-extends it. LH sign-extends the half; LHU zero-extends it. LW passes the word unchanged. Addr[0] is ignored for halves, and Addr[1:0] is ignored for words.
- W_ForwardStoreData = WBSel ? extended load data : ALUData.
- W_RegWrite = registered RegWrite. W_WriteReg = registered WriteReg.
- M_ForwardStoreDataMux_Sel = W_RegWrite && (W_WriteReg != 0) && (W_WriteReg == M_rt). This is purely combinational on the current M_rt.
- Register 0 is never a forwarding target, even if RegWrite is set.

## Timing
- Latency: M inputs captured at edge N appear on the W outputs after edge N, within the same cycle (combinational extraction).
- Sel is same-cycle combinational from the W register and M_rt. It has no added latency.
- Reset values: W_ForwardStoreData = 0, W_WriteReg = 0, W_RegWrite = 0, M_ForwardStoreDataMux_Sel = 0 (and W_AdEL = 0 when configured).
- Reset asserted mid-stream discards the captured instruction. The first post-reset capture requires W_En = 1.
- W_Clr and W_En both high → bubble wins.
- While W_En = 0, outputs remain stable. Sel still tracks changes on M_rt.

## Configuration
- LOAD_ALIGN_CHECK_EN defined:
  - Adds output W_AdEL (1 bit).
  - W_AdEL = 1 when WBSel = 1 and either of these holds:
    - LW-class with Addr[1:0] ≠ 0;
    - LH/LHU with Addr[0] = 1.
  - While W_AdEL = 1, W_RegWrite is forced to 0, so Sel is also 0.
  - W_ForwardStoreData still shows the extracted value.
- LOAD_ALIGN_CHECK_EN undefined: no W_AdEL port; misaligned low bits are silently ignored as described above.

## Test plan
- Reset: hold reset 2 cycles with M_RegWrite = 1 → all outputs 0 and Sel = 0.
- Byte loads: ReadData = 0x80FF_7F01, LB at Addr[1:0] = 3 → 0xFFFF_FF80. LBU at lane 3 → 0x0000_0080. LB at lane 1 → 0x0000_007F.
- Half loads: same word, LH at Addr = 0x2 → 0xFFFF_80FF. LHU at Addr = 0x0 → 0x0000_7F01. LW → 0x80FF_7F01.
- Forwarding: W holds RegWrite = 1, WriteReg = 5, WBSel = 0, ALUData = 0x1234. M_rt = 5 → Sel = 1 and data = 0x1234. M_rt = 6 → Sel = 0. WriteReg = 0 with M_rt = 0 → Sel = 0.
- Control precedence: W_En = 0 with new M inputs → outputs unchanged. W_Clr = 1 with W_En = 1 → W_RegWrite = 0 and data = 0. Reset together with W_Clr → all zero.
- With LOAD_ALIGN_CHECK_EN: LW at Addr = 0x1001 → W_AdEL = 1 and W_RegWrite = 0. LH at Addr = 0x1002 → W_AdEL = 0.

Source files
------------

// File: rtl/w_load_writeback_unit.sv
// W-stage load unit: W pipeline register, load extraction/extension, writeback mux and W->M store-data forward select.
// Optional macro LOAD_ALIGN_CHECK_EN adds the W_AdEL misaligned-load flag and suppresses the register write on it.
module w_load_writeback_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        W_En,
    input  logic        W_Clr,
    input  logic [31:0] M_ReadData,
    input  logic [31:0] M_Addr,
    input  logic [2:0]  M_LoadType,
    input  logic        M_WBSel,
    input  logic [31:0] M_ALUData,
    input  logic        M_RegWrite,
    input  logic [4:0]  M_WriteReg,
    input  logic [4:0]  M_rt,
    output logic [31:0] W_ForwardStoreData,
    output logic [4:0]  W_WriteReg,
    output logic        W_RegWrite,
    output logic        M_ForwardStoreDataMux_Sel
`ifdef LOAD_ALIGN_CHECK_EN
    ,
    output logic        W_AdEL
`endif
);

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic [31:0] read_data_p0;
    logic [1:0]  addr_p0;
    logic [2:0]  load_type_p0;
    logic        wb_sel_p0;
    logic [31:0] alu_data_p0;
    logic        reg_write_p0;
    logic [4:0]  write_reg_p0;
    logic [31:0] load_data;
    logic        reg_write_eff;
    logic        unused_addr_hi;

    // Only the lane-select bits of the address matter past this point.
    assign unused_addr_hi = ^M_Addr[31:2];

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  ltype);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        result;
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        half_s = lane[1] ? word[31:16] : word[15:0];
        case (ltype)
            LT_LB:   result = {{24{byte_s[7]}}, byte_s};
            LT_LBU:  result = {24'd0, byte_s};
            LT_LH:   result = {{16{half_s[15]}}, half_s};
            LT_LHU:  result = {16'd0, half_s};
            default: result = word;
        endcase
        return result;
    endfunction

    // ---- M -> W pipeline register (p0) ----
    always_ff @(posedge clk) begin
        if (reset || W_Clr) begin
            read_data_p0 <= 32'd0;
            addr_p0      <= 2'd0;
            load_type_p0 <= 3'd0;
            wb_sel_p0    <= 1'b0;
            alu_data_p0  <= 32'd0;
            reg_write_p0 <= 1'b0;
            write_reg_p0 <= 5'd0;
        end else if (W_En) begin
            read_data_p0 <= M_ReadData;
            addr_p0      <= M_Addr[1:0];
            load_type_p0 <= M_LoadType;
            wb_sel_p0    <= M_WBSel;
            alu_data_p0  <= M_ALUData;
            reg_write_p0 <= M_RegWrite;
            write_reg_p0 <= M_WriteReg;
        end
    end

    // ---- W stage combinational writeback ----
    assign load_data          = extend_load(read_data_p0, addr_p0, load_type_p0);
    assign W_ForwardStoreData = wb_sel_p0 ? load_data : alu_data_p0;
    assign W_WriteReg         = write_reg_p0;

`ifdef LOAD_ALIGN_CHECK_EN
    logic misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (load_type_p0)
            LT_LB, LT_LBU: misaligned = 1'b0;
            LT_LH, LT_LHU: misaligned = addr_p0[0];
            default:       misaligned = (addr_p0 != 2'd0);
        endcase
    end

    assign W_AdEL        = wb_sel_p0 && misaligned;
    assign reg_write_eff = reg_write_p0 && !W_AdEL;
`else
    assign reg_write_eff = reg_write_p0;
`endif

    assign W_RegWrite = reg_write_eff;

    // Register 0 is hardwired, so it is never a forwarding source.
    assign M_ForwardStoreDataMux_Sel = reg_write_eff && (write_reg_p0 != 5'd0)
                                       && (write_reg_p0 == M_rt);

endmodule

// File: tb/tb_w_load_writeback_unit.sv
// Directed bench for w_load_writeback_unit: reset, load extraction, forwarding select and control precedence.
module tb_w_load_writeback_unit;

    logic        clk;
    logic        reset;
    logic        W_En;
    logic        W_Clr;
    logic [31:0] M_ReadData;
    logic [31:0] M_Addr;
    logic [2:0]  M_LoadType;
    logic        M_WBSel;
    logic [31:0] M_ALUData;
    logic        M_RegWrite;
    logic [4:0]  M_WriteReg;
    logic [4:0]  M_rt;
    logic [31:0] W_ForwardStoreData;
    logic [4:0]  W_WriteReg;
    logic        W_RegWrite;
    logic        M_ForwardStoreDataMux_Sel;
`ifdef LOAD_ALIGN_CHECK_EN
    logic        W_AdEL;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    w_load_writeback_unit dut (
        .clk                       (clk),
        .reset                     (reset),
        .W_En                      (W_En),
        .W_Clr                     (W_Clr),
        .M_ReadData                (M_ReadData),
        .M_Addr                    (M_Addr),
        .M_LoadType                (M_LoadType),
        .M_WBSel                   (M_WBSel),
        .M_ALUData                 (M_ALUData),
        .M_RegWrite                (M_RegWrite),
        .M_WriteReg                (M_WriteReg),
        .M_rt                      (M_rt),
        .W_ForwardStoreData        (W_ForwardStoreData),
        .W_WriteReg                (W_WriteReg),
        .W_RegWrite                (W_RegWrite),
        .M_ForwardStoreDataMux_Sel (M_ForwardStoreDataMux_Sel)
`ifdef LOAD_ALIGN_CHECK_EN
        ,
        .W_AdEL                    (W_AdEL)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] rd, input logic [31:0] addr, input logic [2:0] lt,
                         input logic wbsel, input logic [31:0] alu, input logic rw,
                         input logic [4:0] wr, input logic [4:0] rt);
        M_ReadData = rd;
        M_Addr     = addr;
        M_LoadType = lt;
        M_WBSel    = wbsel;
        M_ALUData  = alu;
        M_RegWrite = rw;
        M_WriteReg = wr;
        M_rt       = rt;
    endtask

    initial begin
        // Reset held two cycles while M presents a live register write
        reset = 1'b1;
        W_En  = 1'b1;
        W_Clr = 1'b0;
        drive(32'h80FF_7F01, 32'h0000_0003, 3'b001, 1'b1, 32'hAAAA_5555, 1'b1, 5'd5, 5'd5);
        step();
        step();
        check("reset_data", W_ForwardStoreData, 32'h0);
        check("reset_wreg", {27'd0, W_WriteReg}, 32'd0);
        check("reset_rw", {31'd0, W_RegWrite}, 32'd0);
        check("reset_sel", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd0);
        reset = 1'b0;

        // Byte and half loads from 0x80FF_7F01
        drive(32'h80FF_7F01, 32'h0000_0003, 3'b001, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lb_lane3", W_ForwardStoreData, 32'hFFFF_FF80);
        check("lb_rw", {31'd0, W_RegWrite}, 32'd1);
        check("lb_wreg", {27'd0, W_WriteReg}, 32'd3);
        drive(32'h80FF_7F01, 32'h0000_0003, 3'b010, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lbu_lane3", W_ForwardStoreData, 32'h0000_0080);
        drive(32'h80FF_7F01, 32'h0000_0001, 3'b001, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lb_lane1", W_ForwardStoreData, 32'h0000_007F);
        drive(32'h80FF_7F01, 32'h0000_0002, 3'b001, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lb_lane2", W_ForwardStoreData, 32'hFFFF_FFFF);
        drive(32'h80FF_7F01, 32'h0000_0002, 3'b011, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lh_hi", W_ForwardStoreData, 32'hFFFF_80FF);
        drive(32'h80FF_7F01, 32'h0000_0000, 3'b100, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lhu_lo", W_ForwardStoreData, 32'h0000_7F01);
        drive(32'h80FF_7F01, 32'h0000_0002, 3'b100, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lhu_hi", W_ForwardStoreData, 32'h0000_80FF);
        drive(32'h80FF_7F01, 32'h0000_0000, 3'b000, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lw", W_ForwardStoreData, 32'h80FF_7F01);
        drive(32'h80FF_7F01, 32'h0000_0000, 3'b110, 1'b1, 32'h0, 1'b1, 5'd3, 5'd0);
        step();
        check("lw_type6", W_ForwardStoreData, 32'h80FF_7F01);

        // Forwarding from an ALU result in W
        drive(32'hDEAD_BEEF, 32'h0, 3'b000, 1'b0, 32'h0000_1234, 1'b1, 5'd5, 5'd5);
        step();
        check("fwd_data", W_ForwardStoreData, 32'h0000_1234);
        check("fwd_sel_match", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd1);
        W_En = 1'b0;
        M_rt = 5'd6;
        #1;
        check("fwd_sel_nomatch", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd0);

        // Hold: new M inputs ignored while W_En = 0
        drive(32'h1111_2222, 32'h3, 3'b001, 1'b1, 32'h0000_9999, 1'b0, 5'd9, 5'd5);
        step();
        check("hold_data", W_ForwardStoreData, 32'h0000_1234);
        check("hold_wreg", {27'd0, W_WriteReg}, 32'd5);
        check("hold_sel", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd1);
        W_En = 1'b1;

        // Register 0 never forwards
        drive(32'h0, 32'h0, 3'b000, 1'b0, 32'h0000_0042, 1'b1, 5'd0, 5'd0);
        step();
        check("r0_rw", {31'd0, W_RegWrite}, 32'd1);
        check("r0_sel", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd0);

        // Bubble wins over W_En
        drive(32'h0, 32'h0, 3'b000, 1'b0, 32'h0000_7777, 1'b1, 5'd7, 5'd7);
        step();
        check("pre_clr_sel", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd1);
        W_Clr = 1'b1;
        drive(32'h0, 32'h0, 3'b000, 1'b0, 32'h0000_8888, 1'b1, 5'd8, 5'd8);
        step();
        check("clr_rw", {31'd0, W_RegWrite}, 32'd0);
        check("clr_data", W_ForwardStoreData, 32'h0);
        check("clr_wreg", {27'd0, W_WriteReg}, 32'd0);
        W_Clr = 1'b0;

        // Reset together with W_Clr, then no capture without W_En
        drive(32'h0, 32'h0, 3'b000, 1'b0, 32'h0000_ABCD, 1'b1, 5'd4, 5'd4);
        step();
        check("pre_rst_data", W_ForwardStoreData, 32'h0000_ABCD);
        reset = 1'b1;
        W_Clr = 1'b1;
        step();
        check("rst_clr_data", W_ForwardStoreData, 32'h0);
        check("rst_clr_rw", {31'd0, W_RegWrite}, 32'd0);
        check("rst_clr_sel", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd0);
        reset = 1'b0;
        W_Clr = 1'b0;
        W_En  = 1'b0;
        step();
        check("post_rst_noen", W_ForwardStoreData, 32'h0);
        W_En = 1'b1;

`ifdef LOAD_ALIGN_CHECK_EN
        drive(32'h80FF_7F01, 32'h0000_1001, 3'b000, 1'b1, 32'h0, 1'b1, 5'd5, 5'd5);
        step();
        check("adel_lw_flag", {31'd0, W_AdEL}, 32'd1);
        check("adel_lw_rw", {31'd0, W_RegWrite}, 32'd0);
        check("adel_lw_sel", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd0);
        check("adel_lw_data", W_ForwardStoreData, 32'h80FF_7F01);
        drive(32'h80FF_7F01, 32'h0000_1002, 3'b011, 1'b1, 32'h0, 1'b1, 5'd5, 5'd5);
        step();
        check("adel_lh_flag", {31'd0, W_AdEL}, 32'd0);
        check("adel_lh_rw", {31'd0, W_RegWrite}, 32'd1);
        check("adel_lh_data", W_ForwardStoreData, 32'hFFFF_80FF);
`else
        // Misaligned low bits are ignored; the write still happens
        drive(32'h80FF_7F01, 32'h0000_1001, 3'b000, 1'b1, 32'h0, 1'b1, 5'd5, 5'd5);
        step();
        check("lw_misaligned_data", W_ForwardStoreData, 32'h80FF_7F01);
        check("lw_misaligned_rw", {31'd0, W_RegWrite}, 32'd1);
        check("lw_misaligned_sel", {31'd0, M_ForwardStoreDataMux_Sel}, 32'd1);
        drive(32'h80FF_7F01, 32'h0000_1003, 3'b011, 1'b1, 32'h0, 1'b1, 5'd5, 5'd5);
        step();
        check("lh_addr0_ignored", W_ForwardStoreData, 32'hFFFF_80FF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
